// File: rtl/mmio_timer_array.sv
// mmio_timer_array: multi-channel memory-mapped timer peripheral.
//   Each channel has a prescaler, a down-counter with reload, a periodic or
//   one-shot mode, and a sticky pending flag. Channel n's registers are at
//   byte offset n*16: CTRL (+0), LOAD (+4), COUNT (+8, read-only), +12 reads 0.
//   STATUS at 0x80 (write-1-to-clear); MASK at 0x84 when irq support is built.
// Optional feature macro: MMIO_TIMER_IRQ_EN adds the MASK register and the irq port.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset
//   sel      - device select; we/re are qualified by it
//   we, re   - write / read strobes
//   addr     - byte offset, bits [1:0] ignored
//   din      - write data
//   dout     - registered read data (1-cycle latency, held between reads)
//   pending  - per-channel sticky expiry flags
//   irq      - |(pending & MASK), only with MMIO_TIMER_IRQ_EN
module mmio_timer_array #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sel,
  input  logic                we,
  input  logic                re,
  input  logic [7:0]          addr,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  output logic [CHANNELS-1:0] pending
`ifdef MMIO_TIMER_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam logic [7:0]  ADDR_STATUS = 8'h80;
  localparam int unsigned CTRL_PS_LSB = 16;
`ifdef MMIO_TIMER_IRQ_EN
  localparam logic [7:0]  ADDR_MASK   = 8'h84;
`endif

  // Per-channel count FSM: IDLE when EN=0, RUN when EN=1.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state        [CHANNELS];
  state_t                w_state_nxt    [CHANNELS];
  logic                  r_mode         [CHANNELS];
  logic                  w_mode_nxt     [CHANNELS];
  logic [PRESCALE_W-1:0] r_prescale     [CHANNELS];
  logic [PRESCALE_W-1:0] w_prescale_nxt [CHANNELS];
  logic [PRESCALE_W-1:0] r_pre          [CHANNELS];
  logic [PRESCALE_W-1:0] w_pre_nxt      [CHANNELS];
  logic [WIDTH-1:0]      r_load         [CHANNELS];
  logic [WIDTH-1:0]      w_load_nxt     [CHANNELS];
  logic [WIDTH-1:0]      r_count        [CHANNELS];
  logic [WIDTH-1:0]      w_count_nxt    [CHANNELS];

  logic [CHANNELS-1:0]   r_pending;
  logic [CHANNELS-1:0]   w_pending_nxt;
  logic [CHANNELS-1:0]   w_expire;
  logic [CHANNELS-1:0]   w_clr;
  logic [31:0]           r_dout;
  logic [31:0]           w_rdata;
  logic [7:0]            w_addr;
  logic                  w_wr;
  logic                  w_rd;

`ifdef MMIO_TIMER_IRQ_EN
  logic [CHANNELS-1:0]   r_mask;
  logic [CHANNELS-1:0]   w_mask_nxt;
  logic                  r_irq;
  logic                  w_irq_nxt;
`endif

  assign w_addr = addr & 8'hFC;
  assign w_wr   = sel & we;
  assign w_rd   = sel & re;

  // Next-state: prescaler/counter advance, then CPU writes override the same cycle.
  always_comb begin
    w_expire = '0;
    w_clr    = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_state_nxt[n]    = r_state[n];
      w_mode_nxt[n]     = r_mode[n];
      w_prescale_nxt[n] = r_prescale[n];
      w_load_nxt[n]     = r_load[n];
      w_count_nxt[n]    = r_count[n];
      w_pre_nxt[n]      = r_pre[n];

      if (r_state[n] == S_RUN) begin
        if (r_pre[n] == r_prescale[n]) begin
          w_pre_nxt[n] = '0;
          if (r_count[n] == '0) begin
            w_expire[n] = 1'b1;
            if (r_mode[n]) begin
              w_state_nxt[n] = S_IDLE;
            end else begin
              w_count_nxt[n] = r_load[n];
            end
          end else begin
            w_count_nxt[n] = r_count[n] - WIDTH'(1);
          end
        end else begin
          w_pre_nxt[n] = r_pre[n] + PRESCALE_W'(1);
        end
      end

      // A CPU write to CTRL or LOAD discards whatever the tick did this cycle.
      if (w_wr && (w_addr == 8'(n * 16))) begin
        w_state_nxt[n]    = din[0] ? S_RUN : S_IDLE;
        w_mode_nxt[n]     = din[1];
        w_prescale_nxt[n] = din[CTRL_PS_LSB +: PRESCALE_W];
        w_count_nxt[n]    = r_count[n];
        w_pre_nxt[n]      = '0;
        w_expire[n]       = 1'b0;
      end
      if (w_wr && (w_addr == 8'(n * 16 + 4))) begin
        w_state_nxt[n] = r_state[n];
        w_load_nxt[n]  = din[WIDTH-1:0];
        w_count_nxt[n] = din[WIDTH-1:0];
        w_pre_nxt[n]   = '0;
        w_expire[n]    = 1'b0;
      end
    end

    if (w_wr && (w_addr == ADDR_STATUS)) begin
      w_clr = din[CHANNELS-1:0];
    end
    // Hardware set beats a simultaneous write-1-to-clear.
    w_pending_nxt = (r_pending & ~w_clr) | w_expire;

`ifdef MMIO_TIMER_IRQ_EN
    w_mask_nxt = r_mask;
    if (w_wr && (w_addr == ADDR_MASK)) begin
      w_mask_nxt = din[CHANNELS-1:0];
    end
    // Registered from next-state values so irq tracks pending with no extra lag.
    w_irq_nxt = |(w_pending_nxt & w_mask_nxt);
`endif
  end

  // Read mux over current register values; unmapped offsets read 0.
  always_comb begin
    w_rdata = '0;
    if (w_addr == ADDR_STATUS) begin
      w_rdata = 32'(r_pending);
    end
`ifdef MMIO_TIMER_IRQ_EN
    if (w_addr == ADDR_MASK) begin
      w_rdata = 32'(r_mask);
    end
`endif
    for (int n = 0; n < CHANNELS; n++) begin
      if (w_addr == 8'(n * 16)) begin
        w_rdata[0]                          = (r_state[n] == S_RUN);
        w_rdata[1]                          = r_mode[n];
        w_rdata[CTRL_PS_LSB +: PRESCALE_W]  = r_prescale[n];
      end
      if (w_addr == 8'(n * 16 + 4)) begin
        w_rdata = 32'(r_load[n]);
      end
      if (w_addr == 8'(n * 16 + 8)) begin
        w_rdata = 32'(r_count[n]);
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_state[n]    <= S_IDLE;
        r_mode[n]     <= 1'b0;
        r_prescale[n] <= '0;
        r_pre[n]      <= '0;
        r_load[n]     <= '0;
        r_count[n]    <= '0;
      end
      r_pending <= '0;
      r_dout    <= '0;
`ifdef MMIO_TIMER_IRQ_EN
      r_mask    <= '0;
      r_irq     <= 1'b0;
`endif
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_state[n]    <= w_state_nxt[n];
        r_mode[n]     <= w_mode_nxt[n];
        r_prescale[n] <= w_prescale_nxt[n];
        r_pre[n]      <= w_pre_nxt[n];
        r_load[n]     <= w_load_nxt[n];
        r_count[n]    <= w_count_nxt[n];
      end
      r_pending <= w_pending_nxt;
      if (w_rd) begin
        r_dout <= w_rdata;
      end
`ifdef MMIO_TIMER_IRQ_EN
      r_mask    <= w_mask_nxt;
      r_irq     <= w_irq_nxt;
`endif
    end
  end

  assign dout    = r_dout;
  assign pending = r_pending;
`ifdef MMIO_TIMER_IRQ_EN
  assign irq     = r_irq;
`endif

endmodule

// File: tb/tb_mmio_timer_array.sv
// tb_mmio_timer_array: self-checking bench for mmio_timer_array.
//   Directed scenarios with hand-derived timing plus a randomized register
//   workout checked against a cycle-level behavioural model of the timers.
module tb_mmio_timer_array;

  localparam int CH = 4;

  logic          clock;
  logic          reset;
  logic          sel;
  logic          we;
  logic          re;
  logic [7:0]    addr;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic [CH-1:0] pending;
`ifdef MMIO_TIMER_IRQ_EN
  logic          irq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mmio_timer_array #(.CHANNELS(CH), .WIDTH(32), .PRESCALE_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .sel     (sel),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .pending (pending)
`ifdef MMIO_TIMER_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural model: plain integers per channel.
  bit [31:0]   m_cnt  [CH];
  bit [31:0]   m_load [CH];
  int          m_pre  [CH];
  int          m_ps   [CH];
  bit          m_en   [CH];
  bit          m_mode [CH];
  bit [CH-1:0] m_pend;
  bit [CH-1:0] m_mask;
  bit [31:0]   m_dout;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_load[c] = 0; m_pre[c] = 0; m_ps[c] = 0;
      m_en[c] = 0; m_mode[c] = 0;
    end
    m_pend = '0;
    m_mask = '0;
    m_dout = '0;
  endfunction

  function automatic bit [31:0] model_read(input logic [7:0] a_in);
    int        a;
    int        c;
    bit [31:0] v;
    a = int'(a_in) & 'hFC;
    v = '0;
    if (a < CH * 16) begin
      c = a / 16;
      case ((a % 16) / 4)
        0: begin
          v[0]     = m_en[c];
          v[1]     = m_mode[c];
          v[31:16] = 16'(m_ps[c]);
        end
        1: v = m_load[c];
        2: v = m_cnt[c];
        default: v = '0;
      endcase
    end else if (a == 'h80) begin
      v = 32'(m_pend);
`ifdef MMIO_TIMER_IRQ_EN
    end else if (a == 'h84) begin
      v = 32'(m_mask);
`endif
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs presented on it.
  function automatic void model_step();
    bit [CH-1:0] set;
    bit [CH-1:0] clr;
    int          a;
    bit          wr_ctrl;
    bit          wr_load;
    set = '0;
    clr = '0;
    a   = int'(addr) & 'hFC;
    if (sel && re) m_dout = model_read(addr);
    for (int c = 0; c < CH; c++) begin
      wr_ctrl = sel && we && (a == c * 16);
      wr_load = sel && we && (a == c * 16 + 4);
      if (wr_ctrl) begin
        m_en[c]   = din[0];
        m_mode[c] = din[1];
        m_ps[c]   = int'(din[31:16]);
        m_pre[c]  = 0;
      end else if (wr_load) begin
        m_load[c] = din;
        m_cnt[c]  = din;
        m_pre[c]  = 0;
      end else if (m_en[c]) begin
        if (m_pre[c] == m_ps[c]) begin
          m_pre[c] = 0;
          if (m_cnt[c] == 0) begin
            set[c] = 1'b1;
            if (m_mode[c]) m_en[c] = 1'b0;
            else           m_cnt[c] = m_load[c];
          end else begin
            m_cnt[c] = m_cnt[c] - 1;
          end
        end else begin
          m_pre[c] = m_pre[c] + 1;
        end
      end
    end
    if (sel && we && a == 'h80) clr = din[CH-1:0];
`ifdef MMIO_TIMER_IRQ_EN
    if (sel && we && a == 'h84) m_mask = din[CH-1:0];
`endif
    m_pend = (m_pend & ~clr) | set;
  endfunction

  // One bus cycle: drive at negedge, step the model at posedge, settle 1 time unit.
  task automatic bus(input logic s, input logic w, input logic r,
                     input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    sel = s; we = w; re = r; addr = a; din = d;
    @(posedge clock);
    model_step();
    #1;
    sel = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    bus(1'b1, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (pending !== '0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_cmp++;
    if (dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
`ifdef MMIO_TIMER_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    @(negedge clock);
    reset = 1'b1;
    rd(8'h00);
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL reset_ctrl0_read: got %h want 0", dout); end
  endtask

  // Channel 0: PRESCALE=0, LOAD=3, periodic -> first expiry 4 edges after CTRL write.
  task automatic test_periodic();
    int  edges;
    bit  seen;
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h1);
    edges = 0; seen = 0;
    while (!seen && edges < 20) begin idle(); edges++; seen = pending[0]; end
    n_cmp++;
    if (edges != 4) begin n_err++; $display("FAIL periodic_first: edges %0d want 4", edges); end
    wr(8'h80, 32'h1);
    n_cmp++;
    if (pending[0] !== 1'b0) begin n_err++; $display("FAIL periodic_w1c: got %b want 0", pending[0]); end
    edges = 0; seen = 0;
    while (!seen && edges < 20) begin idle(); edges++; seen = pending[0]; end
    n_cmp++;
    if (edges != 3) begin n_err++; $display("FAIL periodic_reload: edges %0d want 3", edges); end
    wr(8'h00, 32'h0);
    wr(8'h80, 32'h1);
    n_cmp++;
    if (pending !== m_pend) begin n_err++; $display("FAIL periodic_stop: got %h want %h", pending, m_pend); end
  endtask

  // Channel 1: PRESCALE=9, LOAD=2, one-shot -> single expiry 30 edges after CTRL write.
  task automatic test_oneshot();
    int edges;
    bit seen;
    wr(8'h14, 32'd2);
    wr(8'h10, 32'h0009_0003);
    edges = 0; seen = 0;
    while (!seen && edges < 60) begin idle(); edges++; seen = pending[1]; end
    n_cmp++;
    if (edges != 30) begin n_err++; $display("FAIL oneshot_expiry: edges %0d want 30", edges); end
    rd(8'h10);
    n_cmp++;
    if (dout !== 32'h0009_0002) begin n_err++; $display("FAIL oneshot_ctrl: got %h want 00090002", dout); end
    rd(8'h18);
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL oneshot_count: got %h want 0", dout); end
    wr(8'h80, 32'h2);
    repeat (40) idle();
    n_cmp++;
    if (pending[1] !== 1'b0) begin n_err++; $display("FAIL oneshot_refire: got %b want 0", pending[1]); end
  endtask

  // Channel 2: LOAD write lands on the expiry edge; the expiry is dropped.
  task automatic test_load_collision();
    wr(8'h24, 32'd1);
    wr(8'h20, 32'h1);
    idle();
    wr(8'h24, 32'd7);
    n_cmp++;
    if (pending[2] !== 1'b0) begin n_err++; $display("FAIL loadcol_pending: got %b want 0", pending[2]); end
    rd(8'h28);
    n_cmp++;
    if (dout !== 32'd7) begin n_err++; $display("FAIL loadcol_count: got %0d want 7", dout); end
    wr(8'h20, 32'h0);
  endtask

  // Channel 3: LOAD=0, PRESCALE=0 expires every cycle; W1C loses to the set.
  task automatic test_w1c_collision();
    wr(8'h34, 32'd0);
    wr(8'h30, 32'h1);
    idle();
    wr(8'h80, 32'h8);
    n_cmp++;
    if (pending[3] !== 1'b1) begin n_err++; $display("FAIL w1ccol_setwins: got %b want 1", pending[3]); end
    wr(8'h30, 32'h0);
    wr(8'h80, 32'h8);
    n_cmp++;
    if (pending[3] !== 1'b0) begin n_err++; $display("FAIL w1ccol_clear: got %b want 0", pending[3]); end
  endtask

  task automatic test_mask();
`ifdef MMIO_TIMER_IRQ_EN
    wr(8'h84, 32'h2);
    wr(8'h04, 32'd1);
    wr(8'h00, 32'h1);
    wr(8'h14, 32'd2);
    wr(8'h10, 32'h1);
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) wr(8'h80, 32'h3);
      else            idle();
      n_cmp++;
      if (irq !== m_pend[1]) begin n_err++; $display("FAIL mask_irq: cycle %0d got %b want %b", i, irq, m_pend[1]); end
      n_cmp++;
      if (pending !== m_pend) begin n_err++; $display("FAIL mask_pending: cycle %0d got %h want %h", i, pending, m_pend); end
    end
    wr(8'h00, 32'h0);
    wr(8'h10, 32'h0);
    wr(8'h80, 32'hF);
`else
    wr(8'h84, 32'hF);
    rd(8'h84);
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL mask_absent: got %h want 0", dout); end
`endif
  endtask

  task automatic test_random();
    int          op;
    int          c;
    int          pick;
    logic [7:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 600; i++) begin
      op   = int'($urandom_range(0, 9));
      c    = int'($urandom_range(0, CH - 1));
      pick = int'($urandom_range(0, 9));
      case (pick)
        0, 1:    a = 8'(c * 16);
        2, 3:    a = 8'(c * 16 + 4);
        4:       a = 8'(c * 16 + 8);
        5:       a = 8'(c * 16 + 12);
        6:       a = 8'h80;
        7:       a = 8'h84;
        8:       a = 8'($urandom_range(64, 255));
        default: a = 8'(c * 16 + int'($urandom_range(0, 3)));
      endcase
      d = $urandom;
      if (pick <= 1 || pick == 9) d[31:16] = 16'($urandom_range(0, 3));
      if ((pick == 2 || pick == 3) && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 10));
      if (op <= 3)      idle();
      else if (op <= 6) wr(a, d);
      else              rd(a);
      n_cmp++;
      if (pending !== m_pend) begin n_err++; $display("FAIL rand_pending: step %0d got %h want %h", i, pending, m_pend); end
      if (op >= 7) begin
        n_cmp++;
        if (dout !== m_dout) begin n_err++; $display("FAIL rand_read: step %0d addr %h got %h want %h", i, a, dout, m_dout); end
      end
`ifdef MMIO_TIMER_IRQ_EN
      n_cmp++;
      if (irq !== |(m_pend & m_mask)) begin n_err++; $display("FAIL rand_irq: step %0d got %b want %b", i, irq, |(m_pend & m_mask)); end
`endif
    end
  endtask

  // Reset mid-count on all channels: outputs clear at once, all registers read 0.
  task automatic test_async_reset();
    logic [7:0] a;
    for (int c = 0; c < CH; c++) begin
      wr(8'(c * 16 + 4), (c == 3) ? 32'd0 : 32'd50);
      wr(8'(c * 16), 32'h1);
    end
`ifdef MMIO_TIMER_IRQ_EN
    wr(8'h84, 32'hF);
`endif
    repeat (3) idle();
    rd(8'h08);
    n_cmp++;
    if (dout !== m_dout) begin n_err++; $display("FAIL areset_pre_read: got %h want %h", dout, m_dout); end
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (pending !== '0) begin n_err++; $display("FAIL areset_pending: got %h want 0", pending); end
    n_cmp++;
    if (dout !== '0) begin n_err++; $display("FAIL areset_dout: got %h want 0", dout); end
`ifdef MMIO_TIMER_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL areset_irq: got %b want 0", irq); end
`endif
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < CH * 4 + 2; i++) begin
      a = (i < CH * 4) ? 8'(i * 4) : 8'(128 + (i - CH * 4) * 4);
      rd(a);
      n_cmp++;
      if (dout !== 32'h0) begin n_err++; $display("FAIL areset_read: addr %h got %h want 0", a, dout); end
    end
    n_cmp++;
    if (pending !== '0) begin n_err++; $display("FAIL areset_idle_pending: got %h want 0", pending); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_load_collision();
    test_w1c_collision();
    test_mask();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
